scoreboard_hazard_unit: RTL and testbench

- Parametrised successor of the ID-stage hazard logic.
- Tracks, per architectural register, the cycles until an in-flight result can be bypassed. This supports variable-latency producers (multi-cycle MUL/float ext ALU, loads, IM loads) instead of fixed single-cycle load-use detection.
- Generates the ID-stage stall, supports kill of the instruction just issued into EX on a flow change, and provides halt/drain sequencing.
- Sits beside the decoder, between the IM_ID and ID_EX pipe registers.

---
 rtl/scoreboard_hazard_unit.sv | 117 +++++++++++
 tb/tb_scoreboard_hazard_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scoreboard_hazard_unit.sv
// ID-stage scoreboard: per-register bypass countdown, RAW/WAW stall, EX kill and halt/drain.
// Optional `HAZ_PERF_CNT_EN adds a saturating stall_cycles counter output.
module scoreboard_hazard_unit #(
    parameter  int REG_ADDR_W   = 5,
    parameter  int NUM_RD_PORTS = 2,
    parameter  int LAT_W        = 3,
    localparam int NREGS        = 2**REG_ADDR_W
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               issue_vld,
    input  logic                               issue_we,
    input  logic [REG_ADDR_W-1:0]              issue_dst,
    input  logic [LAT_W-1:0]                   issue_lat,
    input  logic                               issue_hlt,
    input  logic [NUM_RD_PORTS-1:0]            rd_en,
    input  logic [NUM_RD_PORTS*REG_ADDR_W-1:0] rd_addr,
    input  logic                               flush,
    input  logic                               kill_ex,
    output logic                               stall,
    output logic [NUM_RD_PORTS-1:0]            raw_hazard,
    output logic                               waw_hazard,
    output logic [NREGS-1:0]                   busy_vec,
    output logic                               halted,
    output logic                               drained
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]                        stall_cycles
`endif
);

    logic [LAT_W-1:0]      cnt      [NREGS];
    logic [LAT_W-1:0]      cnt_nxt  [NREGS];
    logic                  last_vld;
    logic [REG_ADDR_W-1:0] last_dst;
    logic [LAT_W-1:0]      last_prev;
    logic                  accept;
    logic                  issue_wr;

    function automatic logic [LAT_W-1:0] sat_dec(input logic [LAT_W-1:0] x);
        return (x == '0) ? '0 : x - 1'b1;
    endfunction

    // Hazard checks use pre-issue state, so an instruction never hazards on itself.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        raw_hazard = '0;
        for (int i = 0; i < NUM_RD_PORTS; i++) begin
            raw_hazard[i] = rd_en[i]
                          && (rd_addr[i*REG_ADDR_W +: REG_ADDR_W] != '0)
                          && (cnt[rd_addr[i*REG_ADDR_W +: REG_ADDR_W]] != '0);
        end
    end

    assign waw_hazard = issue_vld && issue_we && (issue_dst != '0) && (cnt[issue_dst] > issue_lat);
    assign stall      = halted || (issue_vld && !flush && ((|raw_hazard) || waw_hazard));
    assign accept     = issue_vld && !flush && !stall;
    assign issue_wr   = accept && issue_we && (issue_dst != '0);

    always_comb begin
        busy_vec = '0;
        for (int r = 0; r < NREGS; r++) begin
            busy_vec[r] = (cnt[r] != '0);
        end
    end

    assign drained = halted && !(|busy_vec);

    // A new issue outranks a kill; a killed write restores the countdown it displaced.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            cnt_nxt[r] = sat_dec(cnt[r]);
        end
        if (issue_wr) begin
            cnt_nxt[issue_dst] = issue_lat;
        end else if (kill_ex && last_vld) begin
            cnt_nxt[last_dst] = sat_dec(last_prev);
        end
        cnt_nxt[0] = '0;
    end

    // NOTE: the counter array is small flop storage, not a RAM, so it is reset with everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                cnt[r] <= '0;
            end
            last_vld  <= 1'b0;
            last_dst  <= '0;
            last_prev <= '0;
            halted    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
            cnt      <= cnt_nxt;
            last_vld <= issue_wr;
            last_dst <= issue_dst;
            if (issue_wr) begin
                last_prev <= sat_dec(cnt[issue_dst]);
            end
            if (accept && issue_hlt) begin
                halted <= 1'b1;
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    // Counts hazard stalls only; the permanent stall after HLT is excluded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (issue_vld && !flush && stall && !halted && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Self-checking bench: directed scenarios plus randomized traffic against a cycle-count reference model.
module tb_scoreboard_hazard_unit;

    localparam int AW    = 5;
    localparam int NP    = 2;
    localparam int LW    = 3;
    localparam int NREGS = 2**AW;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              issue_vld, issue_we, issue_hlt, flush, kill_ex;
    logic [AW-1:0]     issue_dst;
    logic [LW-1:0]     issue_lat;
    logic [NP-1:0]     rd_en;
    logic [NP*AW-1:0]  rd_addr;
    logic              stall, waw_hazard, halted, drained;
    logic [NP-1:0]     raw_hazard;
    logic [NREGS-1:0]  busy_vec;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0]       stall_cycles;
`endif

    scoreboard_hazard_unit #(.REG_ADDR_W(AW), .NUM_RD_PORTS(NP), .LAT_W(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_vld(issue_vld), .issue_we(issue_we), .issue_dst(issue_dst),
        .issue_lat(issue_lat), .issue_hlt(issue_hlt),
        .rd_en(rd_en), .rd_addr(rd_addr), .flush(flush), .kill_ex(kill_ex),
        .stall(stall), .raw_hazard(raw_hazard), .waw_hazard(waw_hazard),
        .busy_vec(busy_vec), .halted(halted), .drained(drained)
`ifdef HAZ_PERF_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: remaining stall cycles per register, plus the last write for kill undo.
    int  m_cnt [NREGS];
    bit  m_last_vld;
    int  m_last_dst;
    int  m_last_prev;
    bit  m_halted;
    longint m_perf;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int dec(input int x);
        return (x > 0) ? x - 1 : 0;
    endfunction

    task automatic model_clear();
        foreach (m_cnt[r]) m_cnt[r] = 0;
        m_last_vld = 0; m_last_dst = 0; m_last_prev = 0; m_halted = 0; m_perf = 0;
    endtask

    task automatic drive_idle();
        issue_vld = 0; issue_we = 0; issue_dst = '0; issue_lat = '0; issue_hlt = 0;
        rd_en = '0; rd_addr = '0; flush = 0; kill_ex = 0;
    endtask

    // Called at a negedge: asserts reset asynchronously, checks cleared outputs, releases.
    task automatic do_reset();
        drive_idle();
        rst_n = 0;
        #1;
        model_clear();
        check("rst_stall", stall, 0);
        check("rst_raw", raw_hazard, 0);
        check("rst_waw", waw_hazard, 0);
        check("rst_busy", busy_vec, 0);
        check("rst_halted", halted, 0);
        check("rst_drained", drained, 0);
`ifdef HAZ_PERF_CNT_EN
        check("rst_perf", stall_cycles, 0);
`endif
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    // One cycle: drive at negedge, compare combinational outputs, advance model at posedge.
    task automatic step(input logic vld, input logic we, input logic [AW-1:0] dst,
                        input logic [LW-1:0] lat, input logic hlt, input logic [NP-1:0] ren,
                        input logic [NP*AW-1:0] raddr, input logic fl, input logic kill,
                        output logic st);
        logic [NP-1:0]    e_raw;
        logic             e_waw, e_stall, acc, wr;
        logic [NREGS-1:0] e_busy;
        int               nc [NREGS];
        int               new_prev;
        issue_vld = vld; issue_we = we; issue_dst = dst; issue_lat = lat; issue_hlt = hlt;
        rd_en = ren; rd_addr = raddr; flush = fl; kill_ex = kill;
        #1;
        for (int i = 0; i < NP; i++) begin
            int a;
            a = int'(raddr[i*AW +: AW]);
            e_raw[i] = ren[i] && a != 0 && m_cnt[a] != 0;
        end
        e_waw   = vld && we && dst != 0 && m_cnt[dst] > int'(lat);
        e_stall = m_halted || (vld && !fl && (e_raw != 0 || e_waw));
        for (int r = 0; r < NREGS; r++) e_busy[r] = m_cnt[r] != 0;
        check("raw_hazard", raw_hazard, e_raw);
        check("waw_hazard", waw_hazard, e_waw);
        check("stall", stall, e_stall);
        check("busy_vec", busy_vec, e_busy);
        check("halted", halted, m_halted);
        check("drained", drained, m_halted && e_busy == 0);
`ifdef HAZ_PERF_CNT_EN
        check("stall_cycles", stall_cycles, m_perf);
`endif
        st = stall;
        @(posedge clk);
        acc = vld && !fl && !e_stall;
        wr  = acc && we && dst != 0;
        for (int r = 0; r < NREGS; r++) nc[r] = dec(m_cnt[r]);
        new_prev = m_last_prev;
        if (wr) begin
            nc[dst]  = int'(lat);
            new_prev = dec(m_cnt[dst]);
        end else if (kill && m_last_vld) begin
            nc[m_last_dst] = dec(m_last_prev);
        end
        if (vld && !fl && e_stall && !m_halted && m_perf < 64'hFFFF_FFFF) m_perf++;
        if (acc && hlt) m_halted = 1;
        m_cnt       = nc;
        m_last_vld  = wr;
        m_last_dst  = int'(dst);
        m_last_prev = new_prev;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic st;
        for (int k = 0; k < n; k++) step(0, 0, '0, '0, 0, '0, '0, 0, 0, st);
    endtask

    function automatic logic [NP*AW-1:0] addr2(input int a0, input int a1);
        logic [NP*AW-1:0] v;
        v = '0;
        v[0 +: AW]  = AW'(a0);
        v[AW +: AW] = AW'(a1);
        return v;
    endfunction

    initial begin
        logic st;
        int   halt_age;
        drive_idle();
        rst_n = 0;
        model_clear();
        @(negedge clk);
        do_reset();

        // RAW on a 2-cycle producer: two stalls, accepted on the third cycle.
        step(1, 1, 5'd3, 3'd2, 0, 2'b00, '0, 0, 0, st);
        check("t1_issue", st, 0);
        for (int k = 0; k < 3; k++) begin
            step(1, 0, '0, '0, 0, 2'b01, addr2(3, 0), 0, 0, st);
            check("t1_consumer", st, k < 2);
        end
        idle(2);

        // Zero-latency producer is bypassed, never busy.
        step(1, 1, 5'd5, 3'd0, 0, 2'b00, '0, 0, 0, st);
        step(1, 0, '0, '0, 0, 2'b10, addr2(0, 5), 0, 0, st);
        check("t2_no_stall", st, 0);
        check("t2_busy5", busy_vec[5], 0);

        // WAW: R7 lat=5 then R7 lat=1 after one idle cycle -> three stalls.
        step(1, 1, 5'd7, 3'd5, 0, 2'b00, '0, 0, 0, st);
        idle(1);
        for (int k = 0; k < 4; k++) begin
            step(1, 1, 5'd7, 3'd1, 0, 2'b00, '0, 0, 0, st);
            check("t3_waw_stall", st, k < 3);
        end
        idle(3);

        // Kill of a write to an idle register clears it.
        step(1, 1, 5'd4, 3'd3, 0, 2'b00, '0, 0, 0, st);
        step(0, 0, '0, '0, 0, 2'b00, '0, 0, 1, st);
        check("t4_busy4", busy_vec[4], 0);
        step(1, 0, '0, '0, 0, 2'b01, addr2(4, 0), 0, 0, st);
        check("t4_no_stall", st, 0);

        // R0 is never tracked.
        step(1, 1, 5'd0, 3'd7, 0, 2'b00, '0, 0, 0, st);
        step(1, 0, '0, '0, 0, 2'b11, addr2(0, 0), 0, 0, st);
        check("t5_no_stall", st, 0);
        check("t5_busy", busy_vec, 0);

        // Halt with R9 outstanding; issue attempts while halted must not count as hazard stalls.
        step(1, 1, 5'd9, 3'd4, 0, 2'b00, '0, 0, 0, st);
        step(1, 0, '0, '0, 1, 2'b00, '0, 1, 0, st);
        check("t6_flushed_hlt", halted, 0);
        step(1, 0, '0, '0, 1, 2'b00, '0, 0, 0, st);
        check("t6_halted", halted, 1);
        for (int k = 0; k < 5; k++) begin
            step(1, 1, 5'd2, 3'd1, 0, 2'b01, addr2(9, 0), 0, 0, st);
            check("t6_halt_stall", st, 1);
        end
        check("t6_drained", drained, 1);
        do_reset();

        // Randomized traffic over a small register window to provoke hazards.
        halt_age = 0;
        for (int k = 0; k < 2000; k++) begin
            logic          vld, we, hlt, fl, kill;
            logic [AW-1:0] dst;
            logic [LW-1:0] lat;
            logic [NP-1:0] ren;
            vld  = ($urandom_range(0, 9) < 8);
            we   = ($urandom_range(0, 9) < 8);
            dst  = AW'($urandom_range(0, 7));
            lat  = LW'($urandom_range(0, 7));
            hlt  = ($urandom_range(0, 79) == 0);
            fl   = ($urandom_range(0, 9) == 0);
            kill = ($urandom_range(0, 7) == 0);
            ren  = NP'($urandom);
            step(vld, we, dst, lat, hlt, ren,
                 addr2($urandom_range(0, 7), $urandom_range(0, 7)), fl, kill, st);
            halt_age = m_halted ? halt_age + 1 : 0;
            if (halt_age > 12 || $urandom_range(0, 399) == 0) begin
                halt_age = 0;
                do_reset();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
